video_pattern_gen: RTL and testbench

//  Source end of the internal 24-bit RGB video stream (din/hs/vs/de/ce). Produces

---
 rtl/video_gen_pkg.sv | 21 ++
 rtl/video_raster_cnt.sv | 39 +++
 rtl/video_pattern_gen.sv | 112 +++++++++++
 tb/tb_video_pattern_gen.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/video_gen_pkg.sv
// video_gen_pkg: pattern codes, bar colours and raster timing helpers
package video_gen_pkg;
    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_GRID  = 2'd1;
    localparam logic [1:0] PAT_RAMP  = 2'd2;
    localparam logic [1:0] PAT_WHITE = 2'd3;
    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] BAR_COLOUR [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };
    function automatic int total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction
    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction
    function automatic int sync_end(input int active, input int fp, input int sync);
        return active + fp + sync;
    endfunction
endpackage

// File: rtl/video_raster_cnt.sv
// video_raster_cnt: pixel-enable divider plus horizontal/vertical raster counters
module video_raster_cnt
    import video_gen_pkg::*;
#(
    parameter int H_TOTAL = 384,
    parameter int V_TOTAL = 262,
    parameter int CE_DIV  = 4,
    parameter int HW = $clog2(H_TOTAL),
    parameter int VW = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          ce,
    output logic          line_wrap,
    output logic          frame_wrap
);
    localparam int DW = CE_DIV > 1 ? $clog2(CE_DIV) : 1;
    logic [DW-1:0] div;
    // ce marks the clk on which the divider wraps; wraps cascade from pixel to line to frame
    always_comb begin
        ce = div == DW'(CE_DIV - 1);
        line_wrap = ce && h == HW'(H_TOTAL - 1);
        frame_wrap = line_wrap && v == VW'(V_TOTAL - 1);
    end
    // divider free-runs; h moves on ce, v moves on line wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
            h <= '0;
            v <= '0;
        end else begin
            div <= ce ? '0 : div + 1'b1;
            if (ce) h <= line_wrap ? '0 : h + 1'b1;
            if (line_wrap) v <= frame_wrap ? '0 : v + 1'b1;
        end
    end
endmodule

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: raster timing and test pattern source; VIDEO_PATTERN_BORDER_EN adds a white 1-px border
module video_pattern_gen
    import video_gen_pkg::*;
#(
    parameter int H_ACTIVE = 320,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 16,
    parameter int V_ACTIVE = 240,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 16,
    parameter int CE_DIV   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  pattern,
    output logic [23:0] dout,
    output logic        hs_out,
    output logic        vs_out,
    output logic        de_out,
    output logic        ce_out
);
    localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int HS0 = sync_start(H_ACTIVE, H_FP);
    localparam int HS1 = sync_end(H_ACTIVE, H_FP, H_SYNC);
    localparam int VS0 = sync_start(V_ACTIVE, V_FP);
    localparam int VS1 = sync_end(V_ACTIVE, V_FP, V_SYNC);
    localparam int BW = H_ACTIVE / 8;
    localparam int BCW = BW > 1 ? $clog2(BW) : 1;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic ce, line_wrap, frame_wrap;
    logic [31:0] hi, vi;
    logic [1:0] pat;
    logic [2:0] bar;
    logic [BCW-1:0] bar_w;
    logic last_w, de, hs, vs;
    logic [23:0] pat_pix, pix;

    video_raster_cnt #(.H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .CE_DIV(CE_DIV)) u_raster (
        .clk(clk),
        .reset(reset),
        .h(h),
        .v(v),
        .ce(ce),
        .line_wrap(line_wrap),
        .frame_wrap(frame_wrap)
    );

    // decode timing and select the pixel from the current (pre-advance) h/v
    always_comb begin
        hi = 32'(h);
        vi = 32'(v);
        last_w = bar_w == BCW'(BW - 1);
        de = hi < H_ACTIVE && vi < V_ACTIVE;
        hs = hi >= HS0 && hi < HS1;
        vs = vi >= VS0 && vi < VS1;
        pat_pix = pat == PAT_BARS ? BAR_COLOUR[bar] :
                  pat == PAT_GRID ? ((hi[3:0] == 4'd0 || vi[3:0] == 4'd0) ? WHITE : 24'h0) :
                  pat == PAT_RAMP ? {3{hi[7:0]}} : WHITE;
`ifdef VIDEO_PATTERN_BORDER_EN
        pix = (hi == 0 || hi == H_ACTIVE - 1 || vi == 0 || vi == V_ACTIVE - 1) ? WHITE : pat_pix;
`else
        pix = pat_pix;
`endif
    end

    // bar index steps every BW active pixels, restarting each line
    always_ff @(posedge clk) begin
        if (reset) begin
            bar <= '0;
            bar_w <= '0;
        end else if (ce) begin
            if (line_wrap) begin
                bar <= '0;
                bar_w <= '0;
            end else if (hi < H_ACTIVE) begin
                bar_w <= last_w ? '0 : bar_w + 1'b1;
                if (last_w) bar <= bar + 1'b1;
            end
        end
    end

    // pattern changes only between frames so a frame never tears
    always_ff @(posedge clk) begin
        if (reset) pat <= PAT_BARS;
        else if (frame_wrap) pat <= pattern;
    end

    // all outputs share one register stage; video fields hold between ce clks
    always_ff @(posedge clk) begin
        if (reset) begin
            ce_out <= 1'b0;
            de_out <= 1'b0;
            hs_out <= 1'b0;
            vs_out <= 1'b0;
            dout <= '0;
        end else begin
            ce_out <= ce;
            if (ce) begin
                de_out <= de;
                hs_out <= hs;
                vs_out <= vs;
                dout <= de ? pix : 24'h0;
            end
        end
    end
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: directed checks plus a per-pixel raster model for video_pattern_gen
module tb_video_pattern_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] pattern = 2'd0;
    logic [23:0] dout, dout1;
    logic hs, vs, de, ce, hs1, vs1, de1, ce1;
    int checks = 0;
    int errors = 0;
    int mh, mv, mpat, sh, sv, clk_cnt, de_cnt, vs_cnt, hs_run, ce_since_fall;
    bit full, seen_fall;
    logic [31:0] last;
    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    always #5 clk = ~clk;

    video_pattern_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2), .V_ACTIVE(8), .V_FP(1),
                        .V_SYNC(2), .V_BP(1), .CE_DIV(2)) u_dut (
        .clk(clk), .reset(reset), .pattern(pattern), .dout(dout),
        .hs_out(hs), .vs_out(vs), .de_out(de), .ce_out(ce)
    );

    video_pattern_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2), .V_ACTIVE(8), .V_FP(1),
                        .V_SYNC(2), .V_BP(1), .CE_DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .pattern(pattern), .dout(dout1),
        .hs_out(hs1), .vs_out(vs1), .de_out(de1), .ce_out(ce1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [26:0] model(input int h, input int v, input int p);
        logic [23:0] px;
        logic d;
        d = h < 16 && v < 8;
        case (p)
            0: px = bar_tab[(h / 2) % 8];
            1: px = (h % 16 == 0 || v % 16 == 0) ? 24'hFFFFFF : 24'h0;
            2: px = {3{8'(h)}};
            default: px = 24'hFFFFFF;
        endcase
`ifdef VIDEO_PATTERN_BORDER_EN
        if (h == 0 || h == 15 || v == 0 || v == 7) px = 24'hFFFFFF;
`endif
        return {d ? px : 24'h0, h >= 18 && h < 22, v >= 9 && v < 11, d};
    endfunction

    task automatic resync();
        mh = 0; mv = 0; mpat = 0; full = 0; seen_fall = 0;
        hs_run = 0; ce_since_fall = 0; clk_cnt = 0; last = '0;
    endtask

    task automatic run_ce(output int clks);
        clks = 0;
        while (1) begin
            @(negedge clk);
            clks++;
            clk_cnt++;
            if (clks > 8) begin
                errors++;
                $display("FAIL ce_timeout waited %0d clks for ce, required at most 2", clks);
                $fatal(1, "pixel enable stopped");
            end
            if (ce) break;
            check("hold", {5'b0, dout, hs, vs, de}, last);
        end
        if (mh == 0 && mv == 0) begin
            if (full) begin
                check("frame_clks", clk_cnt, 576);
                check("frame_de_ce", de_cnt, 128);
                check("frame_vs_ce", vs_cnt, 48);
            end
            full = 1; clk_cnt = 0; de_cnt = 0; vs_cnt = 0;
        end
        last = {5'b0, dout, hs, vs, de};
        check("pix", last, {5'b0, model(mh, mv, mpat)});
        de_cnt += int'(de);
        vs_cnt += int'(vs);
        ce_since_fall++;
        if (hs) hs_run++;
        else if (hs_run > 0) begin
            check("hs_width", hs_run, 4);
            if (seen_fall) check("hs_period", ce_since_fall, 24);
            seen_fall = 1; ce_since_fall = 0; hs_run = 0;
        end
        sh = mh; sv = mv;
        if (mh == 23) begin
            mh = 0;
            if (mv == 11) begin mv = 0; mpat = int'(pattern); end
            else mv++;
        end else mh++;
    endtask

    task automatic run_until(input int th, input int tv);
        int n = 0;
        int c;
        do begin
            run_ce(c);
            n++;
        end while (!(sh == th && sv == tv) && n < 400);
        if (!(sh == th && sv == tv)) begin
            checks++; errors++;
            $display("FAIL reach_pos at h=%0d v=%0d, required h=%0d v=%0d", sh, sv, th, tv);
        end
    endtask

    task automatic do_reset(input int n);
        int c;
        reset = 1'b1;
        repeat (n) begin
            @(negedge clk);
            check("rst_out", {dout, hs, vs, de, ce}, 0);
            check("rst_out1", {dout1, hs1, vs1, de1, ce1}, 0);
        end
        reset = 1'b0;
        resync();
        run_ce(c);
        check("first_ce_clk", c, 2);
    endtask

    initial begin
        int cnt, z;
        logic pv, rose;
        do_reset(3);
        check("bar0", dout, 24'hFFFFFF);
        run_until(2, 1);  check("bar1", dout, 24'hFFFF00);
        run_until(4, 1);  check("bar2", dout, 24'h00FFFF);
        run_until(6, 1);  check("bar3", dout, 24'h00FF00);
        run_until(14, 1); check("bar7", dout, 24'h000000);
        run_until(16, 1); check("blank_dout", {dout, de}, 0);
        run_until(18, 1); check("hs_on", hs, 1);
        run_until(22, 1); check("hs_off", hs, 0);
        run_until(0, 4);
        pattern = 2'd2;
        run_until(2, 4);  check("bars_hold", dout, 24'hFFFF00);
        run_until(0, 9);  check("vs_on", {vs, de}, 2'b10);
        run_until(0, 11); check("vs_off", vs, 0);
        run_until(0, 0);
        run_until(1, 1);  check("ramp1", dout, 24'h010101);
        run_until(14, 1); check("ramp14", dout, 24'h0E0E0E);
        pattern = 2'd1;
        run_until(0, 0);  check("grid_corner", dout, 24'hFFFFFF);
        run_until(5, 0);  check("grid_row0", dout, 24'hFFFFFF);
        run_until(1, 1);  check("grid_in", dout, 24'h000000);
        run_until(0, 3);  check("grid_col0", dout, 24'hFFFFFF);
        run_until(5, 3);  check("grid_in2", dout, 24'h000000);
        pattern = 2'd3;
        run_until(0, 0);
        run_until(7, 7);  check("white", dout, 24'hFFFFFF);
        run_until(0, 5);
        do_reset(3);
        check("restart_bar0", dout, 24'hFFFFFF);
        run_until(2, 1);  check("restart_bar1", dout, 24'hFFFF00);
        run_until(0, 0);
        cnt = 0; pv = vs1;
        do begin
            @(negedge clk); cnt++; rose = vs1 && !pv; pv = vs1;
        end while (!rose && cnt < 1000);
        cnt = 0; z = 0;
        do begin
            @(negedge clk); cnt++; z += int'(!ce1); rose = vs1 && !pv; pv = vs1;
        end while (!rose && cnt < 1000);
        check("ce1_frame_clks", cnt, 288);
        check("ce1_low_clks", z, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
